// File: rtl/udm_uart_pkg.sv
// Shared definitions for the UDM UART blocks: parity modes, rx FSM states,
// divider limits and small helper functions.
package udm_uart_pkg;

  localparam int DIV_W       = 16;
  localparam int DEFAULT_DIV = 608;
  localparam int MIN_DIV     = 4;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_e;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] div,
                                                 input logic [DIV_W-1:0] dflt,
                                                 input logic [DIV_W-1:0] mn);
    logic [DIV_W-1:0] res;
    if (div == {DIV_W{1'b0}}) begin
      res = dflt;
    end else if (div < mn) begin
      res = mn;
    end else begin
      res = div;
    end
    return res;
  endfunction

  function automatic logic parity8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/udm_sync_2ff.sv
// Generic two-flop synchroniser; RESET_VAL sets the value presented while
// in reset so the consumer sees a benign level.
module udm_sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/udm_uart_rx.sv
// UART receiver of the UDM debug bridge: 8 data bits, optional parity, one
// stop bit, runtime baud divider, valid/ready byte output with error pulses.
module udm_uart_rx #(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = udm_uart_pkg::DEFAULT_DIV,
  parameter int MIN_DIV     = udm_uart_pkg::MIN_DIV
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 rx_i,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  input  logic [1:0]           parity_mode_i,
  output logic [7:0]           data_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);
  import udm_uart_pkg::*;

  localparam logic [DIV_WIDTH-1:0] CNT_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] CNT_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic                 rx_s;
  logic                 rx_prev_r;
  rx_state_e            state_r, state_n;
  logic [DIV_WIDTH-1:0] cnt_r, cnt_n;
  logic [DIV_WIDTH-1:0] div_r, div_n, div_sel_s;
  logic [2:0]           idx_r, idx_n;
  logic [7:0]           shift_r, shift_n;
  logic [1:0]           pmode_r, pmode_n;
  logic                 pbad_r, pbad_n;
  logic                 tc_s, par_en_s, good_s, perr_s, ferr_s, accept_s;
  logic [7:0]           data_r;
  logic                 valid_r, ferr_r, perr_r, ovr_r, busy_r;

  udm_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk_i),
    .rst_n (arst_n_i),
    .d     (rx_i),
    .q     (rx_s)
  );

  assign div_sel_s = clamp_div(baud_div_i, DIV_W'(DEFAULT_DIV), DIV_W'(MIN_DIV));
  assign tc_s      = (cnt_r == CNT_ZERO);
  assign par_en_s  = (pmode_r == PARITY_EVEN) || (pmode_r == PARITY_ODD);
  assign accept_s  = valid_r & data_ready_i;

  // FSM state and datapath registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r   <= IDLE;
      rx_prev_r <= 1'b1;
      cnt_r     <= CNT_ZERO;
      div_r     <= CNT_ZERO;
      idx_r     <= 3'd0;
      shift_r   <= 8'h00;
      pmode_r   <= 2'd0;
      pbad_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      rx_prev_r <= rx_s;
      cnt_r     <= cnt_n;
      div_r     <= div_n;
      idx_r     <= idx_n;
      shift_r   <= shift_n;
      pmode_r   <= pmode_n;
      pbad_r    <= pbad_n;
    end
  end

  // next-state, bit timing and frame completion events
  always_comb begin
    state_n = state_r;
    cnt_n   = tc_s ? cnt_r : (cnt_r - CNT_ONE);
    div_n   = div_r;
    idx_n   = idx_r;
    shift_n = shift_r;
    pmode_n = pmode_r;
    pbad_n  = pbad_r;
    good_s  = 1'b0;
    perr_s  = 1'b0;
    ferr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (rx_prev_r && !rx_s) begin
          state_n = START;
          cnt_n   = (div_sel_s >> 1'b1) - CNT_ONE;
          div_n   = div_sel_s;
          pmode_n = parity_mode_i;
          pbad_n  = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (tc_s) begin
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            cnt_n   = div_r - CNT_ONE;
            idx_n   = 3'd0;
          end
        end else begin
          state_n = START;
        end
      end
      DATA: begin
        if (tc_s) begin
          shift_n = {rx_s, shift_r[7:1]};
          cnt_n   = div_r - CNT_ONE;
          idx_n   = idx_r + 3'd1;
          if (idx_r == 3'd7) begin
            state_n = par_en_s ? PARITY : STOP;
          end else begin
            state_n = DATA;
          end
        end else begin
          state_n = DATA;
        end
      end
      PARITY: begin
        if (tc_s) begin
          pbad_n  = (parity8(shift_r) ^ rx_s) != (pmode_r == PARITY_ODD);
          cnt_n   = div_r - CNT_ONE;
          state_n = STOP;
        end else begin
          state_n = PARITY;
        end
      end
      STOP: begin
        if (tc_s) begin
          if (rx_s) begin
            perr_s  = pbad_r;
            good_s  = ~pbad_r;
            state_n = IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end else begin
          state_n = STOP;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_n = IDLE;
        end else begin
          state_n = WAIT_IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // output buffer, handshake and one-cycle error pulses
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      perr_r  <= 1'b0;
      ovr_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      ferr_r <= ferr_s;
      perr_r <= perr_s;
      ovr_r  <= good_s & valid_r & ~accept_s;
      busy_r <= (state_n != IDLE);
      if (good_s && (!valid_r || accept_s)) begin
        data_r  <= shift_r;
        valid_r <= 1'b1;
      end else if (accept_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign data_o       = data_r;
  assign data_valid_o = valid_r;
  assign frame_err_o  = ferr_r;
  assign parity_err_o = perr_r;
  assign overrun_o    = ovr_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_udm_uart_rx.sv
// Scoreboard bench for udm_uart_rx: serial frames are built from the line
// protocol, expected bytes/errors queued, and a monitor checks DUT outputs.
module tb_udm_uart_rx;

  logic        clk = 1'b0;
  logic        arst_n_i;
  logic        rx_i;
  logic [15:0] baud_div_i;
  logic [1:0]  parity_mode_i;
  logic [7:0]  data_o;
  logic        data_valid_o;
  logic        data_ready;
  logic        frame_err_o, parity_err_o, overrun_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_data_q[$];
  int         exp_err_q[$];   // 1 frame error, 2 parity error, 3 overrun
  bit         hold_full = 1'b0;

  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  udm_uart_rx dut (
    .clk_i         (clk),
    .arst_n_i      (arst_n_i),
    .rx_i          (rx_i),
    .baud_div_i    (baud_div_i),
    .parity_mode_i (parity_mode_i),
    .data_o        (data_o),
    .data_valid_o  (data_valid_o),
    .data_ready_i  (data_ready),
    .frame_err_o   (frame_err_o),
    .parity_err_o  (parity_err_o),
    .overrun_o     (overrun_o),
    .busy_o        (busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_err(input string name, input int kind);
    if (exp_err_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected pulse (kind %0d) with nothing expected at %0t", name, kind, $time);
    end else begin
      check(name, kind, exp_err_q.pop_front());
    end
  endtask

  // monitor: consumes expectations whenever the DUT presents an output
  always @(negedge clk) begin
    if (arst_n_i) begin
      if (data_valid_o && data_ready) begin
        if (exp_data_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL byte: unexpected byte 0x%0h with nothing expected at %0t", data_o, $time);
        end else begin
          check("byte", data_o, exp_data_q.pop_front());
        end
      end
      if (frame_err_o)  pop_err("frame_err", 1);
      if (parity_err_o) pop_err("parity_err", 2);
      if (overrun_o)    pop_err("overrun", 3);
      if (prev_hold) begin
        check("valid_held", data_valid_o, 1);
        check("data_stable", data_o, prev_data);
      end
      prev_hold <= data_valid_o && !data_ready;
      prev_data <= data_o;
    end else begin
      prev_hold <= 1'b0;
    end
  end

  task automatic drive_bit(input logic v, input int n);
    rx_i = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int eff_div(input int baud);
    if (baud == 0) return 608;
    if (baud < 4) return 4;
    return baud;
  endfunction

  // one frame on the wire; expectation queued as the stop bit starts
  task automatic send_frame(input logic [7:0] b, input int baud, input logic [1:0] pm,
                            input logic pbit, input logic stop_bit, input int extra_low,
                            input int gap, input int new_baud);
    int  d;
    bit  par_en;
    d = eff_div(baud);
    par_en = (pm == 2'd1) || (pm == 2'd2);
    baud_div_i    = 16'(baud);
    parity_mode_i = pm;
    drive_bit(1'b0, d);
    if (new_baud != 0) baud_div_i = 16'(new_baud);
    for (int i = 0; i < 8; i++) drive_bit(b[i], d);
    if (par_en) drive_bit(pbit, d);
    if (!stop_bit) begin
      exp_err_q.push_back(1);
    end else if (par_en && ((^b ^ pbit) != (pm == 2'd2))) begin
      exp_err_q.push_back(2);
    end else if (!data_ready && hold_full) begin
      exp_err_q.push_back(3);
    end else begin
      exp_data_q.push_back(b);
      if (!data_ready) hold_full = 1'b1;
    end
    drive_bit(stop_bit, d + extra_low);
    drive_bit(1'b1, gap);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k;
    bit         busy_seen;
    logic [7:0] b;
    int         baud, d;
    logic [1:0] pm;
    logic       pbit, stop;

    arst_n_i = 1'b0; rx_i = 1'b1; baud_div_i = 16'd16; parity_mode_i = 2'd0; data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data_o, 0);
    check("rst_valid", data_valid_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_perr", parity_err_o, 0);
    check("rst_ovr", overrun_o, 0);
    check("rst_busy", busy_o, 0);
    arst_n_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // default divider, back-to-back bytes
    send_frame(8'h55, 0, 2'd0, 1'b0, 1'b1, 0, 0, 0);
    send_frame(8'hA3, 0, 2'd0, 1'b0, 1'b1, 0, 20, 0);

    // false start shorter than half a bit at div 608
    busy_seen = 1'b0;
    rx_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (busy_o) busy_seen = 1'b1;
    end
    rx_i = 1'b1;
    check("false_start_busy", busy_seen, 1);
    for (k = 100; k < 310 && busy_o; k++) begin
      @(posedge clk);
      #1;
    end
    check("false_start_idle", busy_o, 0);
    repeat (20) @(posedge clk);
    #1;

    // framing error with long break, then recovery
    send_frame(8'h3C, 16, 2'd0, 1'b0, 1'b0, 40, 32, 0);
    send_frame(8'h81, 16, 2'd0, 1'b0, 1'b1, 0, 20, 0);

    // odd parity: 0x07 has three ones, so parity bit 0 is correct
    send_frame(8'h07, 16, 2'd2, 1'b0, 1'b1, 0, 20, 0);
    send_frame(8'h07, 16, 2'd2, 1'b1, 1'b1, 0, 20, 0);
    send_frame(8'hC4, 16, 2'd1, 1'b1, 1'b1, 0, 20, 0);

    // overrun while consumer stalls
    data_ready = 1'b0;
    hold_full  = 1'b0;
    send_frame(8'h11, 16, 2'd0, 1'b0, 1'b1, 0, 16, 0);
    send_frame(8'h22, 16, 2'd0, 1'b0, 1'b1, 0, 16, 0);
    check("ovr_data_kept", data_o, 8'h11);
    check("ovr_valid_kept", data_valid_o, 1);
    data_ready = 1'b1;
    hold_full  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ovr_valid_drop", data_valid_o, 0);

    // reset in the middle of a data phase
    baud_div_i = 16'd16;
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 48);
    arst_n_i = 1'b0;
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_valid", data_valid_o, 0);
    check("midrst_data", data_o, 0);
    check("midrst_errs", {frame_err_o, parity_err_o, overrun_o}, 0);
    repeat (3) @(posedge clk);
    #1;
    arst_n_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_frame(8'h42, 16, 2'd0, 1'b0, 1'b1, 0, 20, 0);

    // divider change during a frame must not disturb it
    send_frame(8'hA5, 16, 2'd0, 1'b0, 1'b1, 0, 20, 7);

    // randomized frames: divider, parity mode, byte, parity/stop corruption
    for (int n = 0; n < 24; n++) begin
      baud = $urandom_range(1, 20);
      d    = eff_div(baud);
      pm   = 2'($urandom_range(0, 3));
      b    = 8'($urandom);
      pbit = ^b ^ (pm == 2'd2);
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      stop = ($urandom_range(0, 7) != 0);
      if (stop) send_frame(b, baud, pm, pbit, 1'b1, 0, $urandom_range(0, d), 0);
      else      send_frame(b, baud, pm, pbit, 1'b0, $urandom_range(0, 30), d + 2, 0);
    end

    repeat (100) @(posedge clk);
    #1;
    check("bytes_all_seen", exp_data_q.size(), 0);
    check("errors_all_seen", exp_err_q.size(), 0);
    check("final_idle", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
